ysyx_23060096_mem_arbiter: RTL and testbench
============================================

# ysyx_23060096_mem_arbiter

Two-master, single-outstanding memory arbiter that shares the core's single data memory port between the instruction fetch path (IFU) and the load/store path (LSU). It accepts one request at a time, forwards it to the memory slave over a valid/ready handshake, and waits for the response. It routes the response back to the granted master, or returns an error response on timeout. The block sits between the core's IFU/LSU and the memory/bus slave.

## Interface
Parameters:
- TIMEOUT, 255: number of WAIT cycles without a slave response before an error response is returned. Legal range 1..65535.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU read address
- ifu_resp_valid  out  1  one-cycle IFU response pulse
- ifu_rdata  out  32  IFU read data
- ifu_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  32  write data
- lsu_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  one-cycle LSU response pulse
- lsu_rdata  out  32  LSU read data
- lsu_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  request to slave
- mem_req_ready  in  1  slave accepts request
- mem_addr, mem_wdata  out  32  captured address and write data
- mem_wen  out  1  captured write enable (0 for IFU)
- mem_wmask  out  4  captured mask (0 for IFU)
- mem_resp_valid  in  1  slave response
- mem_rdata  in  32  slave read data

## Operation
- States: IDLE, REQ, WAIT.
- **IDLE**
  - Arbitrate among asserted req_valid.
  - Winner's req_ready = 1 combinationally (state==IDLE && grant). The ready-on-valid dependency is intentional.
  - On handshake: capture the winner's addr/wen/wdata/wmask and the grant owner, then go to REQ.
  - IFU requests are captured with wen=0 and wmask=0.
- **REQ**
  - mem_req_valid = 1 with the captured fields, held stable.
  - On mem_req_ready, go to WAIT and clear the timeout counter.
- **WAIT**
  - On mem_resp_valid: register mem_rdata into the owner's rdata, pulse the owner's resp_valid next cycle with err=0, and go to IDLE.
  - Otherwise increment the counter (16 bits). When the counter reaches TIMEOUT-1 without a response: pulse the owner's resp_valid with err=1 and rdata=0, then go to IDLE.
- Response and timeout in the same cycle: the response wins (err=0).
- mem_resp_valid outside WAIT is ignored. A late response after a timeout is discarded.
- The non-owner's resp_valid is always 0. Masters must accept response pulses unconditionally.
- Default arbitration is fixed priority: LSU > IFU.

## Timing
- Reset values: state=IDLE; every valid/ready/err output = 0; all data/address outputs = 0; counter = 0; last_grant = IFU.
- Handshake at cycle T → mem_req_valid high from T+1.
- mem_req_ready at cycle A → WAIT from A+1.
- mem_resp_valid at cycle R → master resp_valid/rdata at R+1, state IDLE at R+1.
- A new request can be accepted at R+1. Best-case throughput is one transaction per 3 cycles (zero-wait slave).
- Timeout: err pulse occurs exactly TIMEOUT cycles after entering WAIT.
- Reset mid-transaction: immediate return to IDLE; the outstanding transaction is abandoned and no response is issued.

## Configuration
- ARB_RR_EN defined:
  - Round-robin arbitration. When both masters are valid, grant the master not recorded in last_grant.
  - last_grant updates on every accepted request.
  - Reset value IFU, so the first contention goes to the LSU.
  - A single requester is always granted.
- ARB_RR_EN undefined: fixed priority LSU > IFU; last_grant is unused.

## Test plan
- IFU only, addr 0x8000_0000, slave ready immediately, resp at A+1 with rdata 0x0000_0513 → ifu_resp_valid pulse, ifu_rdata=0x0000_0513, ifu_err=0, lsu_resp_valid never high.
- LSU write, addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0xF → mem_wen=1 and fields held through REQ. Then mem_req_ready stalled 3 cycles → mem_req_valid stays high with fields stable.
- Both valid for 4 consecutive transactions:
  - without ARB_RR_EN → grant order LSU, LSU, LSU, LSU;
  - with ARB_RR_EN → LSU, IFU, LSU, IFU.
- TIMEOUT=4, slave never responds → lsu_resp_valid with lsu_err=1 and lsu_rdata=0 exactly 4 cycles after WAIT entry. A later mem_resp_valid produces no response pulse.
- Response on the TIMEOUT-1 cycle with rdata 0x1234_5678 → err=0, rdata=0x1234_5678, no second pulse.
- rstn low during WAIT → all outputs 0 immediately. After release, a new IFU request completes normally.

Source files
------------

// File: rtl/ysyx_23060096_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_mem_arbiter_if
// Bundle of every handshake/bus signal around the memory arbiter: the IFU
// request/response channel, the LSU request/response channel and the
// single memory-slave channel.
//
// Modports:
//   slave  - arbiter view: receives IFU/LSU requests and memory responses,
//            drives ready/response pulses and the memory request.
//   master - environment view (core masters + memory slave): drives the
//            requests and the memory responses, observes everything else.
// ---------------------------------------------------------------------------
interface ysyx_23060096_mem_arbiter_if;
  // IFU channel
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  // LSU channel
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  // Memory slave channel
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060096_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_mem_arbiter
// Two-master, single-outstanding arbiter sharing one memory port between the
// instruction fetch path (IFU) and the load/store path (LSU). One request is
// accepted in IDLE, presented to the slave in REQ, and its response awaited
// in WAIT; the response (or a timeout error) is returned to the owner as a
// one-cycle pulse.
//
// Ports:
//   clk   - core clock, all state on the rising edge
//   rstn  - asynchronous active-low reset
//   bus   - ysyx_23060096_mem_arbiter_if.slave (IFU, LSU and memory channels)
// Parameters:
//   TIMEOUT - WAIT cycles without a response before an error reply (1..65535)
// Configuration macro:
//   ARB_RR_EN - round-robin arbitration on contention; when undefined the
//               arbitration is fixed priority LSU > IFU.
// ---------------------------------------------------------------------------
module ysyx_23060096_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  ysyx_23060096_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_fin;
  logic        w_fin_err;

  logic        r_owner_lsu;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wen;
  logic [3:0]  r_wmask;

  logic        r_ifu_vld;
  logic [31:0] r_ifu_rdata;
  logic        r_ifu_err;
  logic        r_lsu_vld;
  logic [31:0] r_lsu_rdata;
  logic        r_lsu_err;

  logic        w_idle;
  logic        w_grant_lsu;
  logic        w_grant_ifu;
  logic        w_hs;

  assign w_idle = (r_state == S_IDLE);

`ifdef ARB_RR_EN
  // 1 = LSU won the last accepted request. Starts at IFU so the first
  // contention goes to the LSU.
  logic r_last_lsu;

  assign w_grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !r_last_lsu);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_lsu <= 1'b0;
    end else if (w_hs) begin
      r_last_lsu <= w_grant_lsu;
    end
  end
`else
  assign w_grant_lsu = bus.lsu_req_valid;
`endif

  assign w_grant_ifu = bus.ifu_req_valid && !w_grant_lsu;
  assign w_hs        = w_idle && (w_grant_lsu || w_grant_ifu);

  // Ready depends combinationally on valid; masters must not wait for ready
  // before raising valid.
  assign bus.lsu_req_ready = w_idle && w_grant_lsu;
  assign bus.ifu_req_ready = w_idle && w_grant_ifu;

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wmask     = r_wmask;

  assign bus.ifu_resp_valid = r_ifu_vld;
  assign bus.ifu_rdata      = r_ifu_rdata;
  assign bus.ifu_err        = r_ifu_err;
  assign bus.lsu_resp_valid = r_lsu_vld;
  assign bus.lsu_rdata      = r_lsu_rdata;
  assign bus.lsu_err        = r_lsu_err;

  // Next-state logic. A response in the last counted cycle beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fin       = 1'b0;
    w_fin_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_state_nxt = S_IDLE;
          w_fin       = 1'b1;
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_fin       = 1'b1;
          w_fin_err   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture: IFU requests are reads, so write fields are zeroed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner_lsu <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wen       <= 1'b0;
      r_wmask     <= 4'd0;
    end else if (w_hs) begin
      r_owner_lsu <= w_grant_lsu;
      r_addr      <= w_grant_lsu ? bus.lsu_addr  : bus.ifu_addr;
      r_wdata     <= w_grant_lsu ? bus.lsu_wdata : 32'd0;
      r_wen       <= w_grant_lsu && bus.lsu_wen;
      r_wmask     <= w_grant_lsu ? bus.lsu_wmask : 4'd0;
    end
  end

  // Response routing: only the owner ever sees a pulse; rdata holds between
  // responses and is forced to zero on a timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ifu_vld   <= 1'b0;
      r_ifu_rdata <= 32'd0;
      r_ifu_err   <= 1'b0;
      r_lsu_vld   <= 1'b0;
      r_lsu_rdata <= 32'd0;
      r_lsu_err   <= 1'b0;
    end else begin
      r_ifu_vld <= w_fin && !r_owner_lsu;
      r_ifu_err <= w_fin && !r_owner_lsu && w_fin_err;
      r_lsu_vld <= w_fin && r_owner_lsu;
      r_lsu_err <= w_fin && r_owner_lsu && w_fin_err;
      if (w_fin && !r_owner_lsu) begin
        r_ifu_rdata <= w_fin_err ? 32'd0 : bus.mem_rdata;
      end
      if (w_fin && r_owner_lsu) begin
        r_lsu_rdata <= w_fin_err ? 32'd0 : bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060096_mem_arbiter
// Self-checking bench for the two-master memory arbiter (TIMEOUT = 4).
// Expected responses are queued when the slave response (or timeout) is set
// up and compared by a monitor when a response pulse appears.
// ---------------------------------------------------------------------------
module tb_ysyx_23060096_mem_arbiter;

  localparam int TO = 4;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_chk;
  int   n_pass;

  ysyx_23060096_mem_arbiter_if bus();

  ysyx_23060096_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // One bit per output (or OR of a bus): all must be zero in reset.
  wire [12:0] w_out_nz = {bus.ifu_req_ready, bus.ifu_resp_valid, |bus.ifu_rdata, bus.ifu_err,
                          bus.lsu_req_ready, bus.lsu_resp_valid, |bus.lsu_rdata, bus.lsu_err,
                          bus.mem_req_valid, |bus.mem_addr, |bus.mem_wdata, bus.mem_wen,
                          |bus.mem_wmask};

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rstn && (bus.ifu_resp_valid || bus.lsu_resp_valid)) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_resp", {bus.lsu_resp_valid, bus.ifu_resp_valid}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk_eq("resp_owner", {bus.lsu_resp_valid, bus.ifu_resp_valid}, mon_e.lsu ? 64'd2 : 64'd1);
        chk_eq("resp_rdata", mon_e.lsu ? bus.lsu_rdata : bus.ifu_rdata, mon_e.rdata);
        chk_eq("resp_err", mon_e.lsu ? bus.lsu_err : bus.ifu_err, mon_e.err);
        chk_eq("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One transaction, entered and left just after a rising edge.
  // mode 0: slave answers rd after rdly WAIT cycles
  // mode 1: slave never answers, then a late response after the timeout
  // mode 2: reset asserted during WAIT
  task automatic run_txn(input bit use_ifu, input bit use_lsu, input bit exp_lsu,
                         input logic [31:0] i_addr, input logic [31:0] l_addr,
                         input logic l_wen, input logic [31:0] l_wdata,
                         input logic [3:0] l_wmask, input logic [31:0] rd,
                         input int stall, input int rdly, input int mode);
    logic [36:0] exp_f;
    int          w_cyc;
    exp_t        e;
    bus.ifu_req_valid = use_ifu;
    bus.ifu_addr      = i_addr;
    bus.lsu_req_valid = use_lsu;
    bus.lsu_addr      = l_addr;
    bus.lsu_wen       = l_wen;
    bus.lsu_wdata     = l_wdata;
    bus.lsu_wmask     = l_wmask;
    exp_f = exp_lsu ? {l_addr, l_wen, l_wmask} : {i_addr, 1'b0, 4'h0};
    @(negedge clk);
    chk_eq("lsu_req_ready", bus.lsu_req_ready, exp_lsu);
    chk_eq("ifu_req_ready", bus.ifu_req_ready, !exp_lsu);
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.ifu_addr      = $urandom;
    bus.lsu_addr      = $urandom;
    bus.lsu_wdata     = $urandom;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) bus.mem_req_ready = 1'b1;
      @(negedge clk);
      chk_eq("mem_req_valid", bus.mem_req_valid, 1'b1);
      chk_eq("mem_fields", {bus.mem_addr, bus.mem_wen, bus.mem_wmask}, exp_f);
      if (exp_lsu) chk_eq("mem_wdata", bus.mem_wdata, l_wdata);
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b0;
    w_cyc = cyc;
    if (mode == 0) begin
      for (int d = 0; d < rdly; d++) begin
        @(negedge clk);
        chk_eq("wait_no_req", bus.mem_req_valid, 1'b0);
        @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = rd;
      e = '{lsu: exp_lsu, rdata: rd, err: 1'b0, cyc: cyc + 1};
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = $urandom;
    end else if (mode == 1) begin
      e = '{lsu: exp_lsu, rdata: 32'd0, err: 1'b1, cyc: w_cyc + TO};
      sb_q.push_back(e);
      repeat (TO + 1) begin
        @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'hBAD0_0BAD;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
      end
    end else begin
      @(posedge clk); #1;
      rstn = 1'b0;
      #2;
      chk_eq("rst_mid_outputs", w_out_nz, 13'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
    end
  endtask

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_pass = 0;
    rstn   = 1'b0;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = 32'd0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = 32'd0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = 32'd0;
    bus.lsu_wmask      = 4'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("reset_outputs", w_out_nz, 13'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // IFU fetch, zero-wait slave
    run_txn(1, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0513, 0, 0, 0);

    // Both masters valid for four back-to-back transactions
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      run_txn(1, 1, (i % 2) == 0, 32'h8000_1000 + 32'(i * 4), 32'h8000_2000 + 32'(i * 4),
              0, 32'h0, 4'h0, 32'hC0DE_0000 + 32'(i), 0, 0, 0);
`else
      run_txn(1, 1, 1'b1, 32'h8000_1000 + 32'(i * 4), 32'h8000_2000 + 32'(i * 4),
              0, 32'h0, 4'h0, 32'hC0DE_0000 + 32'(i), 0, 0, 0);
`endif
    end

    // LSU write with the slave stalling ready for 3 cycles
    run_txn(0, 1, 1, 32'h0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 3, 1, 0);

    // LSU read that times out, followed by a late slave response
    run_txn(0, 1, 1, 32'h0, 32'h8000_0200, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1);

    // IFU read answered in the last cycle before the timeout
    run_txn(1, 0, 0, 32'h8000_0300, 32'h0, 0, 32'h0, 4'h0, 32'h1234_5678, 0, TO - 1, 0);

    // Reset while waiting, then a normal IFU fetch
    run_txn(0, 1, 1, 32'h0, 32'h8000_0400, 1, 32'h5555_AAAA, 4'h3, 32'h0, 0, 0, 2);
    run_txn(1, 0, 0, 32'h8000_0500, 32'h0, 0, 32'h0, 4'h0, 32'hFACE_CAFE, 0, 2, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_eq("sb_empty", sb_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
